// File: rtl/wram_asic_arb.sv
// Word-RAM port arbiter: merges sub-CPU and stamp-ASIC traffic onto one RAM port
// and generates the ASIC clock-enable pulse (asic_sync).
module wram_asic_arb #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned IDLE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wram_mode,
  input  logic        wram_for_sub,
  input  logic        sub_req,
  input  logic        sub_we_lo,
  input  logic        sub_we_hi,
  input  logic [16:0] sub_addr,
  input  logic [15:0] sub_din,
  output logic        sub_ack,
  output logic [15:0] sub_dout,
  input  logic [16:0] asic_addr,
  input  logic [15:0] asic_din,
  input  logic        asic_oe,
  input  logic        asic_we,
  output logic [15:0] asic_dout,
  output logic        asic_sync,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_oe,
  output logic        mem_we_lo,
  output logic        mem_we_hi
);

  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned DW = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(IDLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    ASIC = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [LW-1:0] lat_cnt;
  logic [DW-1:0] div_cnt;
  logic          owner_asic;
  logic          asic_done_q;

  logic asic_ok, asic_pend, sub_cand, asic_cand, lat_last;
  logic start_sub, start_asic, sub_done, asic_done, asic_abort;
  logic tick_due, tick_fire;

  assign asic_ok   = wram_for_sub & ~wram_mode;
  assign asic_pend = asic_ok & (asic_oe | asic_we);
  // A requester still shows its old request during its own ack/sync cycle;
  // masking it there prevents the same access from being issued twice.
  assign sub_cand  = sub_req & ~sub_ack;
  assign asic_cand = asic_pend & ~asic_done_q;
  assign lat_last  = (lat_cnt == LAT_LAST);
  assign tick_due  = (div_cnt == DIV_LAST);
  // An idle tick that would collide with sub_ack is held off by one cycle.
  assign tick_fire = ~asic_pend & tick_due & ~sub_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_sub  = 1'b0;
    start_asic = 1'b0;
    sub_done   = 1'b0;
    asic_done  = 1'b0;
    asic_abort = 1'b0;
    case (state)
      IDLE: begin
        if (sub_cand && (!asic_cand || owner_asic)) begin
          state_n   = SUB;
          start_sub = 1'b1;
        end else if (asic_cand) begin
          state_n    = ASIC;
          start_asic = 1'b1;
        end
      end
      SUB: begin
        if (lat_last) begin
          state_n  = IDLE;
          sub_done = 1'b1;
        end
      end
      ASIC: begin
        if (!asic_ok) begin
          state_n    = IDLE;
          asic_abort = 1'b1;
        end else if (lat_last) begin
          state_n   = IDLE;
          asic_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt     <= '0;
      div_cnt     <= '0;
      owner_asic  <= 1'b1;
      asic_done_q <= 1'b0;
      sub_ack     <= 1'b0;
      asic_sync   <= 1'b0;
      sub_dout    <= '0;
      asic_dout   <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_oe      <= 1'b0;
      mem_we_lo   <= 1'b0;
      mem_we_hi   <= 1'b0;
    end else begin
      sub_ack     <= sub_done;
      asic_done_q <= asic_done;
      asic_sync   <= asic_done | tick_fire;

      if (start_sub || start_asic) lat_cnt <= '0;
      else if (state != IDLE)      lat_cnt <= lat_cnt + LW'(1);

      if (asic_pend || tick_fire) div_cnt <= '0;
      else if (!tick_due)         div_cnt <= div_cnt + DW'(1);

      if (start_sub) begin
        mem_addr  <= sub_addr;
        mem_din   <= sub_din;
        mem_oe    <= ~(sub_we_lo | sub_we_hi);
        mem_we_lo <= sub_we_lo;
        mem_we_hi <= sub_we_hi;
      end else if (start_asic) begin
        mem_addr  <= asic_addr;
        mem_din   <= asic_din;
        mem_oe    <= ~asic_we;
        mem_we_lo <= asic_we;
        mem_we_hi <= asic_we;
      end else if (sub_done || asic_done || asic_abort) begin
        mem_oe    <= 1'b0;
        mem_we_lo <= 1'b0;
        mem_we_hi <= 1'b0;
      end

      if (sub_done && mem_oe)  sub_dout  <= mem_dout;
      if (asic_done && mem_oe) asic_dout <= mem_dout;

      if (sub_done)       owner_asic <= 1'b0;
      else if (asic_done) owner_asic <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wram_asic_arb.sv
// Directed bench for wram_asic_arb: behavioural RAM on the memory port,
// hand-computed expectations per cycle.
module tb_wram_asic_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wram_mode, wram_for_sub;
  logic        sub_req, sub_we_lo, sub_we_hi;
  logic [16:0] sub_addr;
  logic [15:0] sub_din;
  logic        sub_ack;
  logic [15:0] sub_dout;
  logic [16:0] asic_addr;
  logic [15:0] asic_din;
  logic        asic_oe, asic_we;
  logic [15:0] asic_dout;
  logic        asic_sync;
  logic [16:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_oe, mem_we_lo, mem_we_hi;

  logic [15:0] ram [0:131071];
  logic        pl_en;
  logic [16:0] pl_addr;
  logic [15:0] pl_data;

  int errors = 0;
  int checks = 0;
  int coincide = 0;
  logic found;

  always #5 clk = ~clk;

  wram_asic_arb #(.MEM_LAT(2), .IDLE_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .wram_mode(wram_mode), .wram_for_sub(wram_for_sub),
    .sub_req(sub_req), .sub_we_lo(sub_we_lo), .sub_we_hi(sub_we_hi),
    .sub_addr(sub_addr), .sub_din(sub_din),
    .sub_ack(sub_ack), .sub_dout(sub_dout),
    .asic_addr(asic_addr), .asic_din(asic_din),
    .asic_oe(asic_oe), .asic_we(asic_we),
    .asic_dout(asic_dout), .asic_sync(asic_sync),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_oe(mem_oe), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi)
  );

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else begin
      if (mem_we_lo) ram[mem_addr][7:0]  <= mem_din[7:0];
      if (mem_we_hi) ram[mem_addr][15:8] <= mem_din[15:8];
    end
  end
  assign mem_dout = ram[mem_addr];

  always @(negedge clk)
    if (!rst && sub_ack && asic_sync) coincide = coincide + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    wram_mode = 1'b0; wram_for_sub = 1'b1;
    sub_req = 1'b0; sub_we_lo = 1'b0; sub_we_hi = 1'b0; sub_addr = '0; sub_din = '0;
    asic_addr = '0; asic_din = '0; asic_oe = 1'b0; asic_we = 1'b0;
    tick();
    preload(17'h00100, 16'hBEEF);
    preload(17'h00200, 16'hA5A5);
    preload(17'h00300, 16'h5A5A);
    preload(17'h00400, 16'h7777);
    preload(17'h00500, 16'h1111);
    preload(17'h00600, 16'h0000);
    preload(17'h1F000, 16'h0000);
    rst = 1'b0;

    // reset state
    check("rst_sub_ack", {31'd0, sub_ack}, 0);
    check("rst_asic_sync", {31'd0, asic_sync}, 0);
    check("rst_strobes", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 0);
    check("rst_mem_addr", {15'd0, mem_addr}, 0);
    check("rst_douts", {sub_dout, asic_dout}, 0);

    // sub read 0x00100
    sub_req = 1'b1; sub_addr = 17'h00100;
    tick();
    check("sr_oe1", {31'd0, mem_oe}, 1);
    check("sr_addr", {15'd0, mem_addr}, 32'h100);
    check("sr_ack_early", {31'd0, sub_ack}, 0);
    tick();
    check("sr_oe2", {31'd0, mem_oe}, 1);
    tick();
    check("sr_oe_off", {31'd0, mem_oe}, 0);
    check("sr_ack", {31'd0, sub_ack}, 1);
    check("sr_dout", {16'd0, sub_dout}, 32'hBEEF);
    sub_req = 1'b0;
    tick();
    check("sr_ack_pulse", {31'd0, sub_ack}, 0);

    // ASIC write 0x1F000 <- 0x1234
    asic_addr = 17'h1F000; asic_din = 16'h1234; asic_we = 1'b1;
    tick();
    check("aw_we1", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 3);
    check("aw_addr", {15'd0, mem_addr}, 32'h1F000);
    tick();
    check("aw_we2", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 3);
    check("aw_sync_early", {31'd0, asic_sync}, 0);
    tick();
    check("aw_we_off", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 0);
    check("aw_sync", {31'd0, asic_sync}, 1);
    asic_we = 1'b0;
    tick();
    check("aw_sync_pulse", {31'd0, asic_sync}, 0);
    check("aw_ram", {16'd0, ram[17'h1F000]}, 32'h1234);

    // contention: sub first (last owner ASIC), then strict alternation
    sub_req = 1'b1; sub_addr = 17'h00200;
    asic_oe = 1'b1; asic_addr = 17'h00300;
    for (int k = 1; k <= 12; k++) begin
      int ph;
      tick();
      ph = (k - 1) % 6;
      check("alt_ack", {31'd0, sub_ack}, (ph == 2) ? 1 : 0);
      check("alt_sync", {31'd0, asic_sync}, (ph == 5) ? 1 : 0);
      check("alt_oe", {31'd0, mem_oe}, (ph == 0 || ph == 1 || ph == 3 || ph == 4) ? 1 : 0);
      if (ph == 0) check("alt_sub_addr", {15'd0, mem_addr}, 32'h200);
      if (ph == 3) check("alt_asic_addr", {15'd0, mem_addr}, 32'h300);
      if (ph == 2) check("alt_sub_dout", {16'd0, sub_dout}, 32'hA5A5);
      if (ph == 5) check("alt_asic_dout", {16'd0, asic_dout}, 32'h5A5A);
    end
    sub_req = 1'b0; asic_oe = 1'b0;
    tick();

    // 1M mode: ASIC request blocked, idle ticker every 4 cycles
    wram_mode = 1'b1; asic_oe = 1'b1; asic_addr = 17'h00400;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (asic_sync) found = 1'b1;
    end
    check("tick_found", {31'd0, found}, 1);
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        check("tick_gap", {31'd0, asic_sync}, 0);
        check("tick_no_oe", {31'd0, mem_oe}, 0);
      end
      tick();
      check("tick_pulse", {31'd0, asic_sync}, 1);
    end
    wram_mode = 1'b0;
    tick();
    check("mode_start_oe", {31'd0, mem_oe}, 1);
    check("mode_start_addr", {15'd0, mem_addr}, 32'h400);
    tick();
    tick();
    check("mode_sync", {31'd0, asic_sync}, 1);
    check("mode_dout", {16'd0, asic_dout}, 32'h7777);
    asic_oe = 1'b0;
    tick();

    // wram_for_sub falls on first cycle of an ASIC read
    asic_oe = 1'b1; asic_addr = 17'h00500;
    tick();
    check("ab_oe1", {31'd0, mem_oe}, 1);
    wram_for_sub = 1'b0;
    tick();
    check("ab_oe_off", {31'd0, mem_oe}, 0);
    check("ab_no_sync1", {31'd0, asic_sync}, 0);
    tick();
    check("ab_oe_idle", {31'd0, mem_oe}, 0);
    check("ab_no_sync2", {31'd0, asic_sync}, 0);
    check("ab_dout_held", {16'd0, asic_dout}, 32'h7777);
    wram_for_sub = 1'b1;
    tick();
    check("ab_reissue_oe", {31'd0, mem_oe}, 1);
    check("ab_reissue_addr", {15'd0, mem_addr}, 32'h500);
    tick();
    tick();
    check("ab_reissue_sync", {31'd0, asic_sync}, 1);
    check("ab_reissue_dout", {16'd0, asic_dout}, 32'h1111);
    asic_oe = 1'b0;
    tick();

    // reset during a sub write, then the same request again
    sub_req = 1'b1; sub_we_lo = 1'b1; sub_we_hi = 1'b1;
    sub_addr = 17'h00600; sub_din = 16'hCAFE;
    tick();
    check("rw_we", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 3);
    rst = 1'b1;
    tick();
    check("rw_rst_strobes", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 0);
    check("rw_rst_ack", {31'd0, sub_ack}, 0);
    tick();
    check("rw_rst_ack2", {31'd0, sub_ack}, 0);
    rst = 1'b0;
    tick();
    check("rw_again_we", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 3);
    sub_req = 1'b0;
    tick();
    check("rw_drop_ack", {31'd0, sub_ack}, 0);
    tick();
    check("rw_ack", {31'd0, sub_ack}, 1);
    check("rw_strobes_off", {29'd0, mem_oe, mem_we_lo, mem_we_hi}, 0);
    check("rw_ram", {16'd0, ram[17'h00600]}, 32'hCAFE);
    tick();
    check("rw_ack_pulse", {31'd0, sub_ack}, 0);

    check("ack_sync_overlap", coincide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
